switch_select_encoder: RTL and testbench

Encodes four push-button switches into the two select bits that steer the 1-to-4 LED demux. Each switch is synchronised and debounced. On a debounced press, the switch index is latched as a registered 2-bit select, so a single tap picks an LED and the selection persists after release. It sits between the board switch pins and the demux select inputs in the top level, in the opposite direction to the demux: it encodes four lines into an index, where the demux decodes an index onto four lines.

---
 rtl/switch_select_encoder.sv | 114 +++++++++++
 tb/tb_switch_select_encoder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/switch_select_encoder.sv
// switch_select_encoder
//   Turns four push-button switches into the 2-bit select index that drives the LED demux.
//   Each switch is synchronised and debounced. A debounced press (0->1) latches that
//   switch's index as the registered select. The selection persists after release.
//
// Ports
//   i_Clk         system clock, rising edge
//   i_Reset       synchronous, active-high reset
//   i_Switch_1..4 raw switch pins (1 = pressed), asynchronous to i_Clk
//   o_Sel0        select LSB, registered
//   o_Sel1        select MSB, registered
//   o_Sel_Valid   one-cycle pulse when a new selection is latched
//   o_Pressed     debounced switch states, bit 0 = switch 1
module switch_select_encoder #(
    parameter int unsigned DEBOUNCE_LIMIT = 250000
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Switch_1,
    input  logic       i_Switch_2,
    input  logic       i_Switch_3,
    input  logic       i_Switch_4,
    output logic       o_Sel0,
    output logic       o_Sel1,
    output logic       o_Sel_Valid,
    output logic [3:0] o_Pressed
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_LIMIT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_LIMIT - 1);

    logic [3:0] sw_raw;
    logic [3:0] sync1_q;
    logic [3:0] sync2_q;
    logic [3:0] stable_q;
    logic [3:0] stable_dly_q;
    logic [3:0] press;
    logic [1:0] sel_q;
    logic [1:0] sel_d;
    logic       valid_q;
    logic       valid_d;

    assign sw_raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

    // Two-flop synchroniser for the asynchronous pins.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sw_raw;
            sync2_q <= sync1_q;
        end
    end

    // Per-switch debounce: stable only follows sync2 after DEBOUNCE_LIMIT consecutive
    // differing cycles; any return to the old level restarts the count.
    for (genvar g = 0; g < 4; g++) begin : g_debounce
        logic [CntW-1:0] cnt_q;

        always_ff @(posedge i_Clk) begin
            if (i_Reset) begin
                cnt_q       <= '0;
                stable_q[g] <= 1'b0;
            end else if (sync2_q[g] == stable_q[g]) begin
                cnt_q <= '0;
            end else if (cnt_q == CntMax) begin
                cnt_q       <= '0;
                stable_q[g] <= sync2_q[g];
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            stable_dly_q <= '0;
        end else begin
            stable_dly_q <= stable_q;
        end
    end

    // Rising edges only; releases never change the selection.
    assign press = stable_q & ~stable_dly_q;

    // Priority encoder: scanning downwards lets the lowest pressed index win.
    always_comb begin
        sel_d   = sel_q;
        valid_d = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (press[i]) begin
                sel_d   = 2'(i);
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            sel_q   <= 2'b00;
            valid_q <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            valid_q <= valid_d;
        end
    end

    assign o_Sel0      = sel_q[0];
    assign o_Sel1      = sel_q[1];
    assign o_Sel_Valid = valid_q;
    assign o_Pressed   = stable_q;

endmodule

// File: tb/tb_switch_select_encoder.sv
// Bench for switch_select_encoder with DEBOUNCE_LIMIT=4.
// Directed steps in one initial block; expected selections are queued when a press is driven
// and popped by a negedge monitor whenever the DUT pulses o_Sel_Valid.
module tb_switch_select_encoder;

    logic       clk;
    logic       rst;
    logic [3:0] sw;
    logic       sel0;
    logic       sel1;
    logic       sel_valid;
    logic [3:0] pressed;

    int total;
    int bad;
    logic [1:0] exp_q[$];
    logic       mon_en;

    switch_select_encoder #(
        .DEBOUNCE_LIMIT(4)
    ) dut (
        .i_Clk       (clk),
        .i_Reset     (rst),
        .i_Switch_1  (sw[0]),
        .i_Switch_2  (sw[1]),
        .i_Switch_3  (sw[2]),
        .i_Switch_4  (sw[3]),
        .o_Sel0      (sel0),
        .o_Sel1      (sel1),
        .o_Sel_Valid (sel_valid),
        .o_Pressed   (pressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every pulse must match the oldest queued selection; no pulse
    // may appear while nothing is queued.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                chk("spurious_valid", 32'(sel_valid), 32'd0);
            end else if (sel_valid === 1'b1) begin
                chk("sel_on_valid", 32'({sel1, sel0}), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        total  = 0;
        bad    = 0;
        mon_en = 1'b0;
        rst    = 1'b1;
        sw     = 4'b0000;

        // 1. Reset values
        tick(3);
        chk("rst_sel", 32'({sel1, sel0}), 32'd0);
        chk("rst_valid", 32'(sel_valid), 32'd0);
        chk("rst_pressed", 32'(pressed), 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;
        tick(2);

        // 2. Single press latency: switch 3 sampled first at edge 0
        sw[2] = 1'b1;
        exp_q.push_back(2'b10);
        tick(5);  // past edges 0..4
        chk("lat_pressed_e4", 32'(pressed), 32'b0000);
        tick(1);  // edge 5
        chk("lat_pressed_e5", 32'(pressed), 32'b0100);
        chk("lat_valid_e5", 32'(sel_valid), 32'd0);
        tick(1);  // edge 6
        chk("lat_sel_e6", 32'({sel1, sel0}), 32'b10);
        chk("lat_valid_e6", 32'(sel_valid), 32'd1);
        tick(1);  // edge 7
        chk("lat_valid_e7", 32'(sel_valid), 32'd0);
        sw[2] = 1'b0;
        tick(12);
        chk("lat_sel_release", 32'({sel1, sel0}), 32'b10);
        chk("lat_pressed_release", 32'(pressed), 32'b0000);

        // 3. Glitch rejection: 3 cycles rejected, 4 accepted
        sw[1] = 1'b1;
        tick(3);
        sw[1] = 1'b0;
        tick(12);
        chk("glitch3_pressed", 32'(pressed), 32'b0000);
        chk("glitch3_sel", 32'({sel1, sel0}), 32'b10);
        sw[1] = 1'b1;
        exp_q.push_back(2'b01);
        tick(4);
        sw[1] = 1'b0;
        tick(2);  // edge 5 from the first sampled high
        chk("glitch4_pressed", 32'(pressed), 32'b0010);
        tick(12);
        chk("glitch4_sel", 32'({sel1, sel0}), 32'b01);
        chk("glitch4_pressed_rel", 32'(pressed), 32'b0000);

        // 4. Simultaneous press of switches 2 and 4: lowest index wins
        sw = 4'b1010;
        exp_q.push_back(2'b01);
        tick(8);
        chk("simul_pressed", 32'(pressed), 32'b1010);
        chk("simul_sel", 32'({sel1, sel0}), 32'b01);
        sw = 4'b0000;
        tick(12);
        chk("simul_release_sel", 32'({sel1, sel0}), 32'b01);
        chk("simul_release_pressed", 32'(pressed), 32'b0000);

        // 5. Overlapping presses: hold 4, then press 1
        sw[3] = 1'b1;
        exp_q.push_back(2'b11);
        tick(8);
        chk("ovl_sel4", 32'({sel1, sel0}), 32'b11);
        sw[0] = 1'b1;
        exp_q.push_back(2'b00);
        tick(8);
        chk("ovl_sel1", 32'({sel1, sel0}), 32'b00);
        chk("ovl_pressed", 32'(pressed), 32'b1001);
        sw[3] = 1'b0;
        tick(12);
        chk("ovl_rel4_sel", 32'({sel1, sel0}), 32'b00);
        chk("ovl_rel4_pressed", 32'(pressed), 32'b0001);
        sw[0] = 1'b0;
        tick(12);
        chk("ovl_rel1_sel", 32'({sel1, sel0}), 32'b00);
        chk("ovl_rel1_pressed", 32'(pressed), 32'b0000);

        // Move selection off 00 so reset visibly clears it
        sw[3] = 1'b1;
        exp_q.push_back(2'b11);
        tick(6);
        sw[3] = 1'b0;
        tick(12);
        chk("pre_rst_sel", 32'({sel1, sel0}), 32'b11);

        // 6. Reset two cycles into a switch 3 debounce; keep switch 3 held
        sw[2] = 1'b1;
        tick(3);
        rst = 1'b1;
        tick(2);
        chk("mid_rst_sel", 32'({sel1, sel0}), 32'b00);
        chk("mid_rst_valid", 32'(sel_valid), 32'd0);
        chk("mid_rst_pressed", 32'(pressed), 32'b0000);
        rst = 1'b0;
        exp_q.push_back(2'b10);
        tick(6);  // edges 0..5 after deassertion
        chk("post_rst_pressed", 32'(pressed), 32'b0100);
        chk("post_rst_valid_e5", 32'(sel_valid), 32'd0);
        tick(1);  // edge 6 = DEBOUNCE_LIMIT+2
        chk("post_rst_sel", 32'({sel1, sel0}), 32'b10);
        chk("post_rst_valid_e6", 32'(sel_valid), 32'd1);
        sw[2] = 1'b0;
        tick(12);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
